// File: rtl/traffic_pkg.sv
// Shared types and constants for the junction phase controller.
// Interval defaults are also used by the Timer bench.
package traffic_pkg;

    typedef enum logic [2:0] {
        INIT        = 3'd0,
        MAIN_GREEN  = 3'd1,
        MAIN_EXT    = 3'd2,
        MAIN_YELLOW = 3'd3,
        WALK        = 3'd4,
        SIDE_GREEN  = 3'd5,
        SIDE_EXT    = 3'd6,
        SIDE_YELLOW = 3'd7
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [3:0] T_BASE_DEF = 4'd6;
    localparam logic [3:0] T_EXT_DEF  = 4'd3;
    localparam logic [3:0] T_YEL_DEF  = 4'd2;

    typedef struct packed {
        logic [2:0] main_l;
        logic [2:0] side_l;
        logic       walk_l;
    } lamps_t;

    function automatic lamps_t lamp_decode(
        input state_t s
    );
        lamps_t l;
        l.main_l = RED;
        l.side_l = RED;
        l.walk_l = 1'b0;
        case (s)
            MAIN_GREEN,
            MAIN_EXT:    l.main_l = GRN;
            MAIN_YELLOW: l.main_l = YEL;
            WALK:        l.walk_l = 1'b1;
            SIDE_GREEN,
            SIDE_EXT:    l.side_l = GRN;
            SIDE_YELLOW: l.side_l = YEL;
            default:     l.walk_l = 1'b0;
        endcase
        return l;
    endfunction

    function automatic logic [3:0] phase_interval(
        input state_t     s,
        input logic [3:0] t_base,
        input logic [3:0] t_ext,
        input logic [3:0] t_yel
    );
        logic [3:0] v;
        v = 4'd0;
        case (s)
            MAIN_GREEN,
            SIDE_GREEN:  v = t_base;
            MAIN_EXT,
            SIDE_EXT,
            WALK:        v = t_ext;
            MAIN_YELLOW,
            SIDE_YELLOW: v = t_yel;
            default:     v = 4'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/traffic_light_fsm_phase_starter.sv
// Timer load pulse and expiry blanking for each phase entry.
// expired is ignored in the pulse cycle and the cycle after it.
module phase_starter (
    input  logic clock,
    input  logic reset_n,
    input  logic enter,
    input  logic expired,
    output logic start_timer,
    output logic expiry_valid
);

    logic blank_tail;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            start_timer <= 1'b0;
            blank_tail  <= 1'b0;
        end else begin
            start_timer <= enter;
            blank_tail  <= start_timer;
        end
    end

    // Timer still shows the previous phase's expiry until it sees the load
    assign expiry_valid = expired & ~start_timer & ~blank_tail;

endmodule

// File: rtl/traffic_light_fsm.sv
// Phase sequencer for a main/side junction with a pedestrian walk phase.
// Drives the Timer load pulse and interval, and all lamp outputs.
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter logic [3:0] T_BASE = T_BASE_DEF,
    parameter logic [3:0] T_EXT  = T_EXT_DEF,
    parameter logic [3:0] T_YEL  = T_YEL_DEF
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sensor,
    input  logic       walk_request,
    input  logic       expired,
    output logic       start_timer,
    output logic [3:0] value,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk_light
);

    state_t state;
    state_t state_nxt;
    logic   enter;
    logic   expiry_valid;
    logic   walk_pending;
    logic   walk_pending_nxt;
    lamps_t lamps_nxt;

    phase_starter u_starter (
        .clock        (clock),
        .reset_n      (reset_n),
        .enter        (enter),
        .expired      (expired),
        .start_timer  (start_timer),
        .expiry_valid (expiry_valid)
    );

    always_comb begin
        state_nxt = state;
        enter     = 1'b0;
        case (state)
            INIT: begin
                state_nxt = MAIN_GREEN;
                enter     = 1'b1;
            end
            MAIN_GREEN: begin
                if (expiry_valid) begin
                    enter = 1'b1;
                    if (sensor | walk_pending)
                        state_nxt = MAIN_EXT;
                end
            end
            MAIN_EXT: begin
                if (expiry_valid) begin
                    enter     = 1'b1;
                    state_nxt = MAIN_YELLOW;
                end
            end
            MAIN_YELLOW: begin
                if (expiry_valid) begin
                    enter     = 1'b1;
                    state_nxt = walk_pending ? WALK
                                             : SIDE_GREEN;
                end
            end
            WALK: begin
                if (expiry_valid) begin
                    enter     = 1'b1;
                    state_nxt = SIDE_GREEN;
                end
            end
            SIDE_GREEN: begin
                if (expiry_valid) begin
                    enter     = 1'b1;
                    state_nxt = sensor ? SIDE_EXT
                                       : SIDE_YELLOW;
                end
            end
            SIDE_EXT: begin
                if (expiry_valid) begin
                    enter     = 1'b1;
                    state_nxt = SIDE_YELLOW;
                end
            end
            SIDE_YELLOW: begin
                if (expiry_valid) begin
                    enter     = 1'b1;
                    state_nxt = MAIN_GREEN;
                end
            end
            default: begin
                // Corrupted encoding: fall back through a yellow
                enter     = 1'b1;
                state_nxt = MAIN_YELLOW;
            end
        endcase
    end

    always_comb begin
        walk_pending_nxt = walk_pending;
        if (walk_request && (state != WALK))
            walk_pending_nxt = 1'b1;
        if (enter && (state_nxt == WALK))
            walk_pending_nxt = 1'b0;
    end

    assign lamps_nxt = lamp_decode(state_nxt);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= INIT;
            walk_pending <= 1'b0;
            value        <= 4'd0;
            main_lights  <= RED;
            side_lights  <= RED;
            walk_light   <= 1'b0;
        end else begin
            state        <= state_nxt;
            walk_pending <= walk_pending_nxt;
            if (enter)
                value <= phase_interval(state_nxt,
                                        T_BASE,
                                        T_EXT,
                                        T_YEL);
            main_lights  <= lamps_nxt.main_l;
            side_lights  <= lamps_nxt.side_l;
            walk_light   <= lamps_nxt.walk_l;
        end
    end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm with a behavioural Timer
// ticking once every three clocks.
module tb_traffic_light_fsm;
    import traffic_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       sensor = 1'b0;
    logic       walk_request = 1'b0;
    logic       expired;
    logic       start_timer;
    logic [3:0] value;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk_light;

    int checks = 0;
    int failures = 0;

    logic [1:0] tick_div = 2'd0;
    logic [3:0] tcnt = 4'd0;
    logic       exp_model = 1'b0;
    logic       exp_force = 1'b0;

    assign expired = exp_model | exp_force;

    traffic_light_fsm dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sensor       (sensor),
        .walk_request (walk_request),
        .expired      (expired),
        .start_timer  (start_timer),
        .value        (value),
        .main_lights  (main_lights),
        .side_lights  (side_lights),
        .walk_light   (walk_light)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (tick_div == 2'd2) tick_div <= 2'd0;
        else tick_div <= tick_div + 2'd1;
        if (start_timer) begin
            tcnt      <= value;
            exp_model <= 1'b0;
        end else if (tick_div == 2'd2 && tcnt != 4'd0) begin
            tcnt <= tcnt - 4'd1;
            if (tcnt == 4'd1) exp_model <= 1'b1;
        end
    end

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp_v);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            chk("onehot_main", 8'($onehot(main_lights)), 8'd1);
            chk("onehot_side", 8'($onehot(side_lights)), 8'd1);
            chk("conflict",
                8'(main_lights == RED || side_lights == RED), 8'd1);
            chk("walk_only_in_walk", 8'(walk_light),
                8'(dut.state == WALK));
        end
    end

    task automatic expect_phase(input string tag,
                                input state_t st,
                                input logic [3:0] val,
                                input logic [2:0] ml,
                                input logic [2:0] sl,
                                input logic wl);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (start_timer === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_start"}, 8'(seen), 8'd1);
        chk({tag, "_state"}, 8'(dut.state), 8'(st));
        chk({tag, "_value"}, 8'(value), 8'(val));
        chk({tag, "_main"}, 8'(main_lights), 8'(ml));
        chk({tag, "_side"}, 8'(side_lights), 8'(sl));
        chk({tag, "_walk"}, 8'(walk_light), 8'(wl));
        @(negedge clock);
        chk({tag, "_width"}, 8'(start_timer), 8'd0);
        chk({tag, "_hold"}, 8'(value), 8'(val));
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_start", 8'(start_timer), 8'd0);
        chk("rst_value", 8'(value), 8'd0);
        chk("rst_main", 8'(main_lights), 8'(RED));
        chk("rst_side", 8'(side_lights), 8'(RED));
        chk("rst_walk", 8'(walk_light), 8'd0);
        chk("rst_state", 8'(dut.state), 8'(INIT));
        reset_n = 1'b1;

        expect_phase("mg0", MAIN_GREEN, 4'd6, GRN, RED, 1'b0);
        expect_phase("mg1", MAIN_GREEN, 4'd6, GRN, RED, 1'b0);
        expect_phase("mg2", MAIN_GREEN, 4'd6, GRN, RED, 1'b0);

        sensor = 1'b1;
        expect_phase("me", MAIN_EXT, 4'd3, GRN, RED, 1'b0);
        expect_phase("my", MAIN_YELLOW, 4'd2, YEL, RED, 1'b0);
        expect_phase("sg", SIDE_GREEN, 4'd6, RED, GRN, 1'b0);
        expect_phase("se", SIDE_EXT, 4'd3, RED, GRN, 1'b0);
        expect_phase("sy", SIDE_YELLOW, 4'd2, RED, YEL, 1'b0);
        expect_phase("mg3", MAIN_GREEN, 4'd6, GRN, RED, 1'b0);
        sensor = 1'b0;

        @(negedge clock);
        walk_request = 1'b1;
        @(negedge clock);
        walk_request = 1'b0;
        chk("wp_set", 8'(dut.walk_pending), 8'd1);
        expect_phase("w_me", MAIN_EXT, 4'd3, GRN, RED, 1'b0);
        expect_phase("w_my", MAIN_YELLOW, 4'd2, YEL, RED, 1'b0);
        expect_phase("w_walk", WALK, 4'd3, RED, RED, 1'b1);
        chk("wp_clr", 8'(dut.walk_pending), 8'd0);
        expect_phase("w_sg", SIDE_GREEN, 4'd6, RED, GRN, 1'b0);
        expect_phase("w_sy", SIDE_YELLOW, 4'd2, RED, YEL, 1'b0);
        expect_phase("w_mg", MAIN_GREEN, 4'd6, GRN, RED, 1'b0);

        @(negedge clock);
        exp_force = 1'b1;
        @(negedge clock);
        chk("f_entry", 8'(start_timer), 8'd1);
        chk("f_entry_val", 8'(value), 8'd6);
        @(negedge clock);
        chk("f_blank1", 8'(start_timer), 8'd0);
        chk("f_blank1_main", 8'(main_lights), 8'(GRN));
        @(negedge clock);
        chk("f_blank2", 8'(start_timer), 8'd0);
        chk("f_blank2_st", 8'(dut.state), 8'(MAIN_GREEN));
        @(negedge clock);
        chk("f_reentry", 8'(start_timer), 8'd1);
        exp_force = 1'b0;
        expect_phase("f_mg", MAIN_GREEN, 4'd6, GRN, RED, 1'b0);

        sensor = 1'b1;
        expect_phase("r_me", MAIN_EXT, 4'd3, GRN, RED, 1'b0);
        expect_phase("r_my", MAIN_YELLOW, 4'd2, YEL, RED, 1'b0);
        expect_phase("r_sg", SIDE_GREEN, 4'd6, RED, GRN, 1'b0);
        expect_phase("r_se", SIDE_EXT, 4'd3, RED, GRN, 1'b0);
        repeat (3) @(negedge clock);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("ar_start", 8'(start_timer), 8'd0);
        chk("ar_value", 8'(value), 8'd0);
        chk("ar_main", 8'(main_lights), 8'(RED));
        chk("ar_side", 8'(side_lights), 8'(RED));
        chk("ar_walk", 8'(walk_light), 8'd0);
        chk("ar_state", 8'(dut.state), 8'(INIT));
        @(negedge clock);
        sensor = 1'b0;
        reset_n = 1'b1;
        expect_phase("ar_mg", MAIN_GREEN, 4'd6, GRN, RED, 1'b0);
        expect_phase("ar_mg2", MAIN_GREEN, 4'd6, GRN, RED, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
